// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: alignment check, req/ack transaction with
// lane-replicated stores, pipeline stall, and raw word plus controls for the load formatter.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_signload,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        flush,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_word,
   output logic        fmt_full,
   output logic        fmt_half,
   output logic        fmt_byte,
   output logic        fmt_signload,
   output logic [1:0]  fmt_addr2,
   output logic        adel,
   output logic        ades,
   output logic        berr,
   output logic [31:0] badvaddr,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);

   localparam int unsigned TW = 8;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [TW-1:0] timer;

   logic          access_c, is_store_c, is_byte_c, is_half_c, is_word_c, misal_c;
   logic          accept_c, ack_c, tout_c;
   logic [3:0]    be_c;
   logic [31:0]   wdata_c;

   // Request decode and alignment check on the live MEM-stage inputs
   always_comb begin
      access_c   = (mem_rd | mem_wr) & ~flush;
      is_store_c = mem_wr;
      is_byte_c  = (mem_size == 2'b00);
      is_half_c  = (mem_size == 2'b01);
      is_word_c  = mem_size[1];
      misal_c    = (is_half_c & mem_addr[0]) | (is_word_c & (mem_addr[1:0] != 2'b00));
      be_c       = 4'b1111;
      wdata_c    = mem_wdata;
      if (is_store_c) begin
         if (is_byte_c) begin
            be_c    = 4'b0001 << mem_addr[1:0];
            wdata_c = {4{mem_wdata[7:0]}};
         end else if (is_half_c) begin
            be_c    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{mem_wdata[15:0]}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and per-cycle events
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      ack_c     = 1'b0;
      tout_c    = 1'b0;
      case (state)
         S_IDLE: begin
            if (access_c && !misal_c) begin
               accept_c  = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (dm_ack) begin
               ack_c     = 1'b1;
               state_nxt = S_DONE;
            end else if (timer == TLAST) begin
               tout_c    = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Held low throughout reset so the pipeline never sees a stale freeze
   assign stall = rst_n & (accept_c | (state == S_REQ));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer        <= '0;
         ld_valid     <= 1'b0;
         ld_word      <= '0;
         fmt_full     <= 1'b0;
         fmt_half     <= 1'b0;
         fmt_byte     <= 1'b0;
         fmt_signload <= 1'b0;
         fmt_addr2    <= '0;
         adel         <= 1'b0;
         ades         <= 1'b0;
         berr         <= 1'b0;
         badvaddr     <= '0;
         dm_req       <= 1'b0;
         dm_we        <= 1'b0;
         dm_be        <= '0;
         dm_addr      <= '0;
         dm_wdata     <= '0;
      end else begin
         ld_valid <= 1'b0;
         adel     <= 1'b0;
         ades     <= 1'b0;
         berr     <= 1'b0;
         if (state == S_IDLE && access_c && misal_c) begin
            adel     <= ~is_store_c;
            ades     <= is_store_c;
            badvaddr <= mem_addr;
         end
         if (accept_c) begin
            timer        <= '0;
            dm_req       <= 1'b1;
            dm_we        <= is_store_c;
            dm_be        <= be_c;
            dm_addr      <= {mem_addr[31:2], 2'b00};
            dm_wdata     <= wdata_c;
            fmt_full     <= is_word_c;
            fmt_half     <= is_half_c;
            fmt_byte     <= is_byte_c;
            fmt_signload <= mem_signload;
            fmt_addr2    <= mem_addr[1:0];
         end
         if (state == S_REQ && !ack_c && !tout_c) timer <= timer + TW'(1);
         if (ack_c) begin
            dm_req <= 1'b0;
            if (!dm_we) begin
               ld_word  <= dm_rdata;
               ld_valid <= 1'b1;
            end
         end
         if (tout_c) begin
            dm_req   <= 1'b0;
            berr     <= 1'b1;
            badvaddr <= mem_addr;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_rd, mem_wr, mem_signload, flush;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        stall, ld_valid;
   logic [31:0] ld_word;
   logic        fmt_full, fmt_half, fmt_byte, fmt_signload;
   logic [1:0]  fmt_addr2;
   logic        adel, ades, berr;
   logic [31:0] badvaddr;
   logic        dm_req, dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   int checks   = 0;
   int failures = 0;

   mem_access_ctrl #(.TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_signload(mem_signload), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .flush(flush), .stall(stall), .ld_valid(ld_valid), .ld_word(ld_word),
      .fmt_full(fmt_full), .fmt_half(fmt_half), .fmt_byte(fmt_byte),
      .fmt_signload(fmt_signload), .fmt_addr2(fmt_addr2),
      .adel(adel), .ades(ades), .berr(berr), .badvaddr(badvaddr),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_rd = 0; mem_wr = 0; mem_size = 2'b00; mem_signload = 0;
      mem_addr = 0; mem_wdata = 0; flush = 0; dm_ack = 0; dm_rdata = 0;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      repeat (3) step();
      chk("rst_stall", 32'(stall), 0);
      chk("rst_dm_req", 32'(dm_req), 0);
      chk("rst_badvaddr", badvaddr, 0);
      rst_n = 1;
      step();

      // lb signed @0x103, ack in first REQ cycle
      mem_rd = 1; mem_size = 2'b00; mem_signload = 1; mem_addr = 32'h103;
      #1 chk("lb_stall_c1", 32'(stall), 1);
      step();
      chk("lb_dm_req", 32'(dm_req), 1);
      chk("lb_dm_addr", dm_addr, 32'h100);
      chk("lb_dm_be", 32'(dm_be), 32'hF);
      chk("lb_dm_we", 32'(dm_we), 0);
      chk("lb_stall_c2", 32'(stall), 1);
      chk("lb_fmt_byte", 32'(fmt_byte), 1);
      chk("lb_fmt_full", 32'(fmt_full), 0);
      chk("lb_fmt_addr2", 32'(fmt_addr2), 3);
      dm_ack = 1; dm_rdata = 32'h80FF_0000;
      step();
      dm_ack = 0; dm_rdata = 0;
      chk("lb_stall_c3", 32'(stall), 0);
      chk("lb_ld_valid", 32'(ld_valid), 1);
      chk("lb_ld_word", ld_word, 32'h80FF_0000);
      chk("lb_fmt_signload", 32'(fmt_signload), 1);
      chk("lb_dm_req_done", 32'(dm_req), 0);
      mem_rd = 0; mem_signload = 0;
      step();
      chk("lb_ld_valid_drop", 32'(ld_valid), 0);
      chk("lb_ld_word_hold", ld_word, 32'h80FF_0000);

      // sh @0x202
      mem_wr = 1; mem_size = 2'b01; mem_addr = 32'h202; mem_wdata = 32'h0000_ABCD;
      step();
      chk("sh_dm_we", 32'(dm_we), 1);
      chk("sh_dm_be", 32'(dm_be), 32'hC);
      chk("sh_dm_wdata", dm_wdata, 32'hABCD_ABCD);
      chk("sh_dm_addr", dm_addr, 32'h200);
      chk("sh_fmt_half", 32'(fmt_half), 1);
      dm_ack = 1;
      step();
      dm_ack = 0;
      chk("sh_ld_valid", 32'(ld_valid), 0);
      chk("sh_stall_done", 32'(stall), 0);
      chk("sh_ld_word_hold", ld_word, 32'h80FF_0000);
      mem_wr = 0;
      step();

      // sb @0x201
      mem_wr = 1; mem_size = 2'b00; mem_addr = 32'h201; mem_wdata = 32'h1234_565A;
      step();
      chk("sb_dm_be", 32'(dm_be), 32'h2);
      chk("sb_dm_wdata", dm_wdata, 32'h5A5A_5A5A);
      dm_ack = 1;
      step();
      dm_ack = 0; mem_wr = 0;
      step();

      // misaligned lw @0x106
      mem_rd = 1; mem_size = 2'b10; mem_addr = 32'h106;
      #1 chk("adel_stall", 32'(stall), 0);
      step();
      chk("adel_pulse", 32'(adel), 1);
      chk("adel_ades", 32'(ades), 0);
      chk("adel_badvaddr", badvaddr, 32'h106);
      chk("adel_dm_req", 32'(dm_req), 0);
      mem_rd = 0;
      step();
      chk("adel_drop", 32'(adel), 0);
      chk("adel_dm_req2", 32'(dm_req), 0);

      // sw with no ack: berr after 15 REQ cycles
      mem_wr = 1; mem_size = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h1234_5678;
      step();
      for (int i = 1; i <= 15; i++) begin
         chk($sformatf("to_req_c%0d", i), {30'd0, dm_req, berr}, 32'h2);
         step();
      end
      chk("to_berr", 32'(berr), 1);
      chk("to_badvaddr", badvaddr, 32'h300);
      chk("to_dm_req", 32'(dm_req), 0);
      chk("to_stall", 32'(stall), 0);
      chk("to_ld_valid", 32'(ld_valid), 0);
      mem_wr = 0;
      step();
      chk("to_berr_drop", 32'(berr), 0);
      chk("to_idle_req", 32'(dm_req), 0);

      // lw with ack exactly at REQ cycle 15: no berr
      mem_rd = 1; mem_size = 2'b11; mem_addr = 32'h400;
      step();
      repeat (14) step();
      chk("ack15_still_req", 32'(dm_req), 1);
      chk("ack15_fmt_full", 32'(fmt_full), 1);
      dm_ack = 1; dm_rdata = 32'hCAFE_F00D;
      step();
      dm_ack = 0; dm_rdata = 0;
      chk("ack15_berr", 32'(berr), 0);
      chk("ack15_ld_valid", 32'(ld_valid), 1);
      chk("ack15_ld_word", ld_word, 32'hCAFE_F00D);
      mem_rd = 0;
      step();

      // flush blocks acceptance in IDLE
      mem_rd = 1; mem_size = 2'b10; mem_addr = 32'h500; flush = 1;
      #1 chk("flush_stall", 32'(stall), 0);
      step();
      chk("flush_dm_req", 32'(dm_req), 0);
      step();
      chk("flush_dm_req2", 32'(dm_req), 0);
      chk("flush_adel", 32'(adel), 0);
      idle_inputs();
      step();

      // reset while in REQ
      mem_rd = 1; mem_size = 2'b00; mem_addr = 32'h601;
      step();
      chk("mid_req_up", 32'(dm_req), 1);
      rst_n = 0;
      #1;
      chk("mid_rst_dm_req", 32'(dm_req), 0);
      chk("mid_rst_stall", 32'(stall), 0);
      chk("mid_rst_ld_word", ld_word, 0);
      chk("mid_rst_fmt_byte", 32'(fmt_byte), 0);
      chk("mid_rst_dm_addr", dm_addr, 0);
      idle_inputs();
      step();
      rst_n = 1;
      step();
      chk("post_rst_dm_req", 32'(dm_req), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
